// File: rtl/div_seq_pkg.sv
// Shared types and sizing for the iterative divider sequencer.
// States, operand width and iteration-counter width used by div_seq and its bench.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_WIDTH = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divStateT;

endpackage

// File: rtl/div_seq_if.sv
// Handshake and data bundle between the execute stage and the divider sequencer.
// The pipeline drives through master; the divider sits on slave.
interface div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opa_i;
  logic [WIDTH-1:0]   opb_i;
  logic               cancel_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, cancel_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, cancel_i,
    output stall_o, ready_o, result_o
  );

endinterface

// File: rtl/div_seq_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Relies on rem < divisor on entry, so a WIDTH+1-bit trial result carries a valid sign bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    remNext = shifted[WIDTH-1:0];
    quoNext = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      remNext = trial[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for the execute stage: stalls the pipeline while
// iterating one quotient bit per cycle, then presents {remainder, quotient} for one cycle.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  div_seq_if.slave  bus
);

  localparam int             CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);

  divStateT         state;
  divStateT         stateNext;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisorReg;
  logic             quoNeg;
  logic             remNeg;
  logic [2*WIDTH-1:0] resultReg;

  logic             stall;
  logic             ready;
  logic             loadOps;
  logic             stepEn;
  logic             lastStep;
  logic             divZero;
  logic             opaNeg;
  logic             opbNeg;
  logic [WIDTH-1:0] opaAbs;
  logic [WIDTH-1:0] opbAbs;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] remFixed;
  logic [WIDTH-1:0] quoFixed;

  // Magnitudes are taken modulo 2^WIDTH, so the most negative value maps onto itself.
  assign divZero  = (bus.opb_i == '0);
  assign opaNeg   = bus.signed_i & bus.opa_i[WIDTH-1];
  assign opbNeg   = bus.signed_i & bus.opb_i[WIDTH-1];
  assign opaAbs   = opaNeg ? -bus.opa_i : bus.opa_i;
  assign opbAbs   = opbNeg ? -bus.opb_i : bus.opb_i;
  assign remFixed = remNeg ? -remNext : remNext;
  assign quoFixed = quoNeg ? -quoNext : quoNext;

  div_step #(.WIDTH(WIDTH)) step (
    .rem     (remReg),
    .quo     (quoReg),
    .divisor (divisorReg),
    .remNext (remNext),
    .quoNext (quoNext)
  );

  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    ready     = 1'b0;
    loadOps   = 1'b0;
    stepEn    = 1'b0;
    lastStep  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          stall     = 1'b1;
          loadOps   = 1'b1;
          stateNext = divZero ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall  = 1'b1;
        stepEn = 1'b1;
        if (count == LAST_COUNT) begin
          lastStep  = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        ready     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // A flush wins over everything, including the final BUSY->DONE step.
    if (bus.cancel_i) begin
      stall     = 1'b0;
      ready     = 1'b0;
      loadOps   = 1'b0;
      stepEn    = 1'b0;
      lastStep  = 1'b0;
      stateNext = IDLE;
    end
  end

  // The sign-corrected result is captured on the last iteration so it is already
  // registered while DONE is presenting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      quoNeg     <= 1'b0;
      remNeg     <= 1'b0;
      resultReg  <= '0;
    end else begin
      state <= stateNext;
      if (loadOps) begin
        remReg     <= '0;
        quoReg     <= opaAbs;
        divisorReg <= opbAbs;
        quoNeg     <= opaNeg ^ opbNeg;
        remNeg     <= opaNeg;
        count      <= '0;
        if (divZero) begin
          resultReg <= {bus.opa_i, {WIDTH{1'b1}}};
        end
      end else if (stepEn) begin
        remReg <= remNext;
        quoReg <= quoNext;
        count  <= count + 1'b1;
      end
      if (lastStep) begin
        resultReg <= {remFixed, quoFixed};
      end
      if (bus.cancel_i) begin
        count <= '0;
      end
    end
  end

  assign bus.stall_o  = stall;
  assign bus.ready_o  = ready;
  assign bus.result_o = resultReg;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotients/remainders, stall lengths,
// divide-by-zero, flush, reset and back-to-back behaviour.
module tb_div_seq
  import div_pkg::*;
;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic start, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic cancel);
    bus.start_i  = start;
    bus.signed_i = sgn;
    bus.opa_i    = a;
    bus.opb_i    = b;
    bus.cancel_i = cancel;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Call just after a rising edge with the divider idle; returns on a falling edge.
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int expStall, input logic [63:0] expResult);
    int stallCycles;
    int guard;
    applyStimulus(1'b1, sgn, a, b, 1'b0);
    stallCycles = 0;
    guard       = 0;
    @(negedge clk);
    while (bus.stall_o === 1'b1 && guard < 100) begin
      stallCycles++;
      guard++;
      @(negedge clk);
    end
    checkOutput({tag, " stall cycles"}, 64'(stallCycles), 64'(expStall));
    checkOutput({tag, " ready"}, 64'(bus.ready_o), 64'd1);
    checkOutput({tag, " result"}, bus.result_o, expResult);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput({tag, " ready drop"}, 64'(bus.ready_o), 64'd0);
    checkOutput({tag, " result hold"}, bus.result_o, expResult);
  endtask

  initial begin
    int readyCount;
    int pulses;
    int pulseCycle [2];
    logic [63:0] pulseResult [2];

    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset stall", 64'(bus.stall_o), 64'd0);
    checkOutput("reset ready", 64'(bus.ready_o), 64'd0);
    checkOutput("reset result", bus.result_o, 64'd0);
    checkOutput("reset state", 64'(dut.state), 64'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    runDiv("divu 100/7", 1'b0, 32'd100, 32'd7, 33, {32'h2, 32'hE});
    @(posedge clk); #1;
    runDiv("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(posedge clk); #1;
    runDiv("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'h1, 32'hFFFF_FFFD});
    @(posedge clk); #1;
    runDiv("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
    @(posedge clk); #1;
    runDiv("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'h0});
    @(posedge clk); #1;
    runDiv("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'h0, 32'hFFFF_FFFF});
    @(posedge clk); #1;
    runDiv("divu 5/0", 1'b0, 32'd5, 32'd0, 1, {32'h5, 32'hFFFF_FFFF});
    @(posedge clk); #1;
    runDiv("div -7/0", 1'b1, 32'hFFFF_FFF9, 32'd0, 1, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

    // Flush together with a start in IDLE must not accept it.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'd1, 32'd1, 1'b1);
    @(negedge clk);
    checkOutput("idle cancel stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("idle cancel state", 64'(dut.state), 64'(IDLE));

    // Flush at BUSY iteration 10.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    bus.cancel_i = 1'b1;
    @(negedge clk);
    checkOutput("busy cancel count", 64'(dut.count), 64'd10);
    checkOutput("busy cancel stall", 64'(bus.stall_o), 64'd0);
    checkOutput("busy cancel ready", 64'(bus.ready_o), 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("after cancel state", 64'(dut.state), 64'(IDLE));
    checkOutput("after cancel stall", 64'(bus.stall_o), 64'd0);
    readyCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) readyCount++;
    end
    checkOutput("cancel no ready", 64'(readyCount), 64'd0);
    @(posedge clk); #1;
    runDiv("divu 9/3", 1'b0, 32'd9, 32'd3, 33, {32'h0, 32'h3});

    // Reset in the middle of an iteration.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid reset state", 64'(dut.state), 64'(IDLE));
    checkOutput("mid reset stall", 64'(bus.stall_o), 64'd0);
    checkOutput("mid reset ready", 64'(bus.ready_o), 64'd0);
    checkOutput("mid reset result", bus.result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back: start held through DONE, operands swapped as the first leaves E.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
    pulses        = 0;
    pulseCycle[0] = 0;
    pulseCycle[1] = 0;
    pulseResult[0] = '0;
    pulseResult[1] = '0;
    for (int c = 0; c < 120 && pulses < 2; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin
        pulseCycle[pulses]  = c;
        pulseResult[pulses] = bus.result_o;
        pulses++;
        if (pulses == 1) begin
          @(posedge clk); #1;
          bus.opa_i = 32'd1000;
          bus.opb_i = 32'd10;
        end
      end
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("b2b pulses", 64'(pulses), 64'd2);
    checkOutput("b2b spacing", 64'(pulseCycle[1] - pulseCycle[0]), 64'd34);
    checkOutput("b2b first result", pulseResult[0], {32'h2, 32'hE});
    checkOutput("b2b second result", pulseResult[1], {32'h0, 32'd100});
    readyCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) readyCount++;
    end
    checkOutput("b2b no third pulse", 64'(readyCount), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative multi-cycle divider sequencer for the execute stage of the 5-stage MIPS pipeline. It accepts DIV/DIVU operands from E, holds the pipeline through `stall_o` (wired to the hazard unit's `div_stallE`) while a restoring shift-subtract datapath runs one quotient bit per cycle, and then presents the {HI, LO} result for one cycle. An exception flush from M aborts an in-flight operation.

## Interface
- `WIDTH`, 32: operand width; the result is 2×WIDTH.
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  DIV/DIVU valid in E; held high by the pipeline while stalled.
- `signed_i`  in  1  1 = DIV, 0 = DIVU; sampled together with `start_i`.
- `opa_i`  in  WIDTH  dividend (rs).
- `opb_i`  in  WIDTH  divisor (rt).
- `cancel_i`  in  1  exception flush (`is_exceptM`); aborts the operation.
- `stall_o`  out  1  to `div_stallE`; freezes F/D/E and bubbles M.
- `ready_o`  out  1  result valid; HI/LO write enable.
- `result_o`  out  2×WIDTH  {remainder → HI, quotient → LO}.

## Operation
- States:
  - IDLE: waiting for a start.
  - BUSY: iterating.
  - DONE: result presented.
- IDLE:
  - `start_i & ~cancel_i`: latch |opa|, |opb|, quotient sign (`signed_i & (opa[MSB]^opb[MSB])`) and remainder sign (`signed_i & opa[MSB]`). Clear the counter.
  - If `opb_i == 0`, go to DONE. Otherwise go to BUSY.
- BUSY:
  - Each cycle, shift {rem, quo} left by 1.
  - Trial subtract: rem − divisor, computed WIDTH+1 bits wide. If the result is non-negative, keep it and set quo[0] = 1.
  - Counter increments. When the counter reaches WIDTH−1, go to DONE.
- DONE:
  - `ready_o = 1`.
  - Apply sign fix: negate quo if the quotient sign is set; negate rem if the remainder sign is set.
  - Next state is always IDLE. `start_i`, still high this cycle, is ignored because the E instruction advances at the end of DONE.
- Divide by zero: quotient = all ones, remainder = `opa_i` unmodified. No trap.
- Signed 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0, which falls out of the modular negate.
- Absolute value is taken on WIDTH bits: |0x8000_0000| = 0x8000_0000 unsigned.
- `cancel_i` in any state: next state is IDLE and the counter clears. `ready_o` is never asserted for the aborted operation, and `stall_o` is forced low in that cycle.
- `cancel_i` has priority over `start_i` and over the BUSY→DONE transition.

## Timing
- Reset values:
  - state = IDLE, counter = 0, internal registers = 0.
  - `stall_o` = 0, `ready_o` = 0, `result_o` = 0.
- `stall_o` is combinational: `(IDLE & start_i | BUSY) & ~cancel_i`. It is asserted in the same cycle the DIV enters E.
- Latency, nonzero divisor:
  - 1 cycle IDLE-accept, then WIDTH BUSY cycles, then 1 DONE cycle.
  - `stall_o` is high for WIDTH+1 = 33 cycles.
  - The instruction occupies E for 34 cycles.
- Latency, zero divisor: 1 stall cycle, then DONE.
- `result_o` is registered and valid only while `ready_o` = 1. It holds its last value otherwise.
- Back-to-back divides: the second `start_i` is accepted in the first IDLE cycle after DONE. There is no dead cycle beyond DONE→IDLE.
- `rst` mid-operation: next cycle is IDLE and all outputs take their reset values.

## Structure
- Package `div_pkg`:
  - state enum {IDLE, BUSY, DONE}.
  - `DIV_WIDTH = 32`.
  - Counter width `$clog2(DIV_WIDTH)`.
- Sub-module `div_step`: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside `div_seq`; the FSM, counter, sign latches and sign fix-up stay in `div_seq`.

## Test plan
- DIVU 100 / 7 → `stall_o` high exactly 33 cycles, then `ready_o` = 1 with `result_o` = {0x2, 0xE}, and `stall_o` = 0 in that cycle.
- DIV −7 (0xFFFF_FFF9) / 2 → quotient 0xFFFF_FFFD (−3), remainder 0xFFFF_FFFF (−1). Also 0x8000_0000 / 0xFFFF_FFFF → {0x0, 0x8000_0000}.
- DIVU 5 / 0 → `stall_o` high 1 cycle, then `ready_o` with {0x5, 0xFFFF_FFFF}.
- `cancel_i` pulsed at BUSY cycle 10 → `stall_o` low in that cycle, FSM in IDLE next cycle, no `ready_o` ever. A fresh 9 / 3 issued right after completes normally with {0, 3}.
- `rst` asserted mid-BUSY → the next cycle shows all outputs 0 and state IDLE.
- Two DIVU back-to-back (`start_i` held through DONE) → exactly two `ready_o` pulses, 34 cycles apart, with both results correct.
